// File: rtl/pipelined_rcla_adder.sv
// pipelined_rcla_adder: WIDTH-bit adder built from 4-bit CLA units grouped
// into SEG_W-bit segments, one segment resolved per pipeline stage, with a
// valid/ready handshake and full backpressure.
// Optional feature macro: PRCLA_OVF_EN adds the registered signed-overflow
// output ovf. Without it there is no ovf port and no extra flop.
// WIDTH must be a multiple of SEG_W, SEG_W a multiple of 4, and NSEG >= 2.
module pipelined_rcla_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef PRCLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NU   = SEG_W / 4;

  // One segment: per-unit 4-bit look-ahead plus a second-level look-ahead
  // over unit Go/Po. Returns {segment carry-out, segment sum}.
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] a,
                                             input logic [SEG_W-1:0] b,
                                             input logic             c);
    logic [SEG_W-1:0] g, p, cb;
    logic [NU-1:0]    ug, up;
    logic [NU:0]      uc;
    logic             t;
    int               b0;
    g = a & b;
    p = a ^ b;
    for (int u = 0; u < NU; u++) begin
      b0 = 4 * u;
      ug[u] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1]) |
              (p[b0+3] & p[b0+2] & p[b0+1] & g[b0]);
      up[u] = &p[b0 +: 4];
    end
    // flat sum-of-products unit carries, no ripple between units
    for (int u = 0; u <= NU; u++) begin
      uc[u] = 1'b0;
      for (int j = 0; j < u; j++) begin
        t = ug[j];
        for (int m = j + 1; m < u; m++) t = t & up[m];
        uc[u] = uc[u] | t;
      end
      t = c;
      for (int m = 0; m < u; m++) t = t & up[m];
      uc[u] = uc[u] | t;
    end
    for (int u = 0; u < NU; u++) begin
      b0 = 4 * u;
      cb[b0]   = uc[u];
      cb[b0+1] = g[b0] | (p[b0] & uc[u]);
      cb[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & uc[u]);
      cb[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0]) |
                 (p[b0+2] & p[b0+1] & p[b0] & uc[u]);
    end
    return {uc[NU], p ^ cb};
  endfunction

  logic             r_v [NSEG];
  logic             r_c [NSEG];
  logic [WIDTH-1:0] r_s [NSEG];
  logic [WIDTH-1:0] r_x [NSEG-1];
  logic [WIDTH-1:0] r_y [NSEG-1];

  logic [SEG_W-1:0] w_a   [NSEG];
  logic [SEG_W-1:0] w_b   [NSEG];
  logic             w_ci  [NSEG];
  logic [SEG_W:0]   w_res [NSEG];
  logic             w_en;

  assign w_en      = !r_v[NSEG-1] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[NSEG-1];
  assign sum       = {r_c[NSEG-1], r_s[NSEG-1]};

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign w_a[k]  = x[SEG_W-1:0];
      assign w_b[k]  = y[SEG_W-1:0];
      assign w_ci[k] = cin;
    end else begin : g_next
      assign w_a[k]  = r_x[k-1][k*SEG_W +: SEG_W];
      assign w_b[k]  = r_y[k-1][k*SEG_W +: SEG_W];
      assign w_ci[k] = r_c[k-1];
    end
    assign w_res[k] = seg_add(w_a[k], w_b[k], w_ci[k]);
  end

  // Pipeline registers: every stage shifts together whenever the output side
  // is empty or being accepted; bubbles shift like valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_s[k] <= '0;
      end
      for (int k = 0; k < NSEG - 1; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
    end else if (w_en) begin
      r_v[0] <= in_valid;
      r_c[0] <= w_res[0][SEG_W];
      r_s[0] <= '0;
      r_s[0][SEG_W-1:0] <= w_res[0][SEG_W-1:0];
      r_x[0] <= x;
      r_y[0] <= y;
      for (int k = 1; k < NSEG; k++) begin
        r_v[k] <= r_v[k-1];
        r_c[k] <= w_res[k][SEG_W];
        r_s[k] <= r_s[k-1];
        r_s[k][k*SEG_W +: SEG_W] <= w_res[k][SEG_W-1:0];
      end
      for (int k = 1; k < NSEG - 1; k++) begin
        r_x[k] <= r_x[k-1];
        r_y[k] <= r_y[k-1];
      end
    end
  end

`ifdef PRCLA_OVF_EN
  logic r_ovf;
  logic w_c_msb;

  // Carry into the MSB equals the top unit's C3; recovered here from the
  // MSB sum bit, since s = p ^ c at that position.
  assign w_c_msb = w_res[NSEG-1][SEG_W-1] ^ w_a[NSEG-1][SEG_W-1] ^ w_b[NSEG-1][SEG_W-1];
  assign ovf     = r_ovf;

  // Overflow flag captured with the final segment, held during stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_en) r_ovf <= w_c_msb ^ w_res[NSEG-1][SEG_W];
  end
`endif

endmodule

// File: tb/tb_pipelined_rcla_adder.sv
// Randomised and directed bench for pipelined_rcla_adder against an
// arithmetic reference: each accepted pair contributes x+y+cin to a slot
// pipeline that advances only when the output is empty or consumed.
module tb_pipelined_rcla_adder;
  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   sum;
`ifdef PRCLA_OVF_EN
  logic             ovf;
`endif

  pipelined_rcla_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum)
`ifdef PRCLA_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference slots: slot NSEG-1 is what the output should present
  logic           m_v [NSEG];
  logic [WIDTH:0] m_s [NSEG];
  logic           m_o [NSEG];

  task automatic chk(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    logic signed [WIDTH+1:0] r;
    r = $signed({{2{a[WIDTH-1]}}, a}) + $signed({{2{b[WIDTH-1]}}, b}) + $signed({{(WIDTH+1){1'b0}}, c});
    return r[WIDTH] != r[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [WIDTH-1:0] v;
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    v = '0;
    for (int i = 0; i < WIDTH; i += 32) v = (v << 32) | WIDTH'($urandom);
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NSEG; k++) begin
      m_v[k] = 1'b0;
      m_s[k] = '0;
      m_o[k] = 1'b0;
    end
  endtask

  // One clock: drive after the falling edge, compare, then advance the model
  // to what the next rising edge should produce.
  task automatic tick(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input logic ordy);
    logic en;
    @(negedge clk);
    in_valid = iv; x = a; y = b; cin = c; out_ready = ordy;
    #1;
    chk("out_valid", {{WIDTH{1'b0}}, out_valid}, {{WIDTH{1'b0}}, m_v[NSEG-1]});
    if (m_v[NSEG-1]) begin
      chk("sum", sum, m_s[NSEG-1]);
`ifdef PRCLA_OVF_EN
      chk("ovf", {{WIDTH{1'b0}}, ovf}, {{WIDTH{1'b0}}, m_o[NSEG-1]});
`endif
    end
    en = !m_v[NSEG-1] | ordy;
    chk("in_ready", {{WIDTH{1'b0}}, in_ready}, {{WIDTH{1'b0}}, en});
    if (en) begin
      for (int k = NSEG - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_s[k] = m_s[k-1];
        m_o[k] = m_o[k-1];
      end
      m_v[0] = iv;
      m_s[0] = ref_sum(a, b, c);
      m_o[0] = ref_ovf(a, b, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear at once.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
    chk("rst_sum", sum, '0);
`ifdef PRCLA_OVF_EN
    chk("rst_ovf", {{WIDTH{1'b0}}, ovf}, '0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {{WIDTH{1'b0}}, in_ready}, {{WIDTH{1'b0}}, 1'b1});
  endtask

  initial begin
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] maxpos;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    one = '0;
    one[0] = 1'b1;
    maxpos = '1;
    maxpos[WIDTH-1] = 1'b0;
    model_clear();

    // reset state
    rst = 1'b1;
    #1;
    chk("init_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
    chk("init_sum", sum, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_in_ready", {{WIDTH{1'b0}}, in_ready}, {{WIDTH{1'b0}}, 1'b1});

    // carry through every segment, via y=1 and via cin=1
    tick(1'b1, '1, one, 1'b0, 1'b1);
    tick(1'b1, '1, '0, 1'b1, 1'b1);
    idle(NSEG + 2);

    // streaming (i, 3i)
    for (int i = 0; i < 8; i++) begin
      a = WIDTH'(i);
      b = WIDTH'(3 * i);
      tick(1'b1, a, b, 1'b0, 1'b1);
    end
    idle(NSEG + 2);

    // backpressure: keep offering while the consumer stalls, then drain
    for (int i = 0; i < NSEG + 5; i++) tick(1'b1, rnd_op(), rnd_op(), 1'(i), 1'b0);
    idle(NSEG + 3);

    // reset with three operations in flight
    for (int i = 0; i < 3; i++) tick(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1);
    pulse_reset();
    idle(NSEG + 2);

    // signed overflow corners
    tick(1'b1, maxpos, one, 1'b0, 1'b1);
    tick(1'b1, '1, '1, 1'b0, 1'b1);
    tick(1'b1, ~maxpos, '1, 1'b0, 1'b1);
    idle(NSEG + 2);

    // random traffic with random backpressure
    for (int i = 0; i < 4000; i++)
      tick(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    idle(NSEG + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "timeout");
  end
endmodule
